// File: rtl/kmat_decode_stream.sv
// rtl/kmat_decode_stream.sv - Reads the K matrix from a synchronous memory, rounds each element to B bits and streams/packs the result.
`ifndef L5_LEN_MU
`define L5_LEN_MU 256
`endif

module kmat_decode_stream #(
  parameter int T      = 4,
  parameter int NBAR   = 8,
  parameter int LEN_MU = `L5_LEN_MU,
  localparam int N_EL  = NBAR * NBAR,
  localparam int N_WD  = N_EL / T,
  localparam int AW    = (N_WD > 1) ? $clog2(N_WD) : 1,
  localparam int RW    = $clog2(N_WD + 1),
  localparam int OW    = T * 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_sec_level,
  output logic              o_k_mat_en,
  output logic [AW-1:0]     o_k_mat_addr,
  input  logic [T*16-1:0]   i_k_mat,
  output logic              o_kw_valid,
  output logic [OW-1:0]     o_kw_data,
  output logic              o_kw_last,
  input  logic              i_kw_ready,
  output logic [LEN_MU-1:0] o_k,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      sec;
  logic [RW-1:0]   rd_ptr;
  logic [AW-1:0]   cap_ptr;
  logic            inflight;
  logic [OW-1:0]   f_data [2];
  logic [1:0]      f_last;
  logic            wr_idx, rd_idx;
  logic [1:0]      count;
  logic            err_q;

  logic            legal, accept, pop, issue;
  logic [2:0]      total;
  logic [2:0]      bw;
  logic [3:0]      dsh;
  logic [3:0]      mask;
  logic [16:0]     rnd;
  logic [OW-1:0]   dec_word;
  logic [LEN_MU-1:0] k_ins;
  int              k_sh;

  assign legal  = (i_sec_level == 3'd1) || (i_sec_level == 3'd3) || (i_sec_level == 3'd5);
  assign accept = (state == IDLE) && i_start && legal;
  assign o_kw_valid = (count != 2'd0);
  assign pop    = o_kw_valid && i_kw_ready;
  // Words already requested from memory count against FIFO space so nothing is ever dropped.
  assign total  = 3'(count) + 3'(inflight);
  assign issue  = (state == RUN) && (rd_ptr < RW'(N_WD)) && (total < (3'd2 + 3'(pop)));

  assign o_k_mat_en   = issue;
  assign o_k_mat_addr = (state == IDLE) ? '0 : rd_ptr[AW-1:0];
  assign o_kw_data    = o_kw_valid ? f_data[rd_idx] : '0;
  assign o_kw_last    = o_kw_valid && f_last[rd_idx];
  assign o_done       = (state == DONE);
  assign o_busy       = (state != IDLE);
  assign o_err        = err_q;

  // L1 uses D=15, so bit 15 is masked and the rounding constant matches L3 (D-B=13).
  always_comb begin
    bw   = 3'd4;
    dsh  = 4'd12;
    mask = 4'hF;
    rnd  = 17'h00800;
    case (sec)
      3'd1: begin bw = 3'd2; dsh = 4'd13; mask = 4'h3; rnd = 17'h01000; end
      3'd3: begin bw = 3'd3; dsh = 4'd13; mask = 4'h7; rnd = 17'h01000; end
      default: ;
    endcase
  end

  always_comb begin
    logic [15:0] c;
    logic [16:0] s;
    logic [3:0]  k;
    dec_word = '0;
    for (int j = 0; j < T; j++) begin
      c = i_k_mat[16*j +: 16];
      if (sec == 3'd1) c[15] = 1'b0;
      s = {1'b0, c} + rnd;
      k = 4'(s >> dsh) & mask;
      dec_word = dec_word | (OW'(k) << (j * int'(bw)));
    end
    k_sh  = int'(cap_ptr) * T * int'(bw);
    k_ins = LEN_MU'(dec_word) << k_sh;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (pop && o_kw_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sec      <= 3'd0;
      rd_ptr   <= '0;
      cap_ptr  <= '0;
      inflight <= 1'b0;
      f_data[0] <= '0;
      f_data[1] <= '0;
      f_last   <= 2'b00;
      wr_idx   <= 1'b0;
      rd_idx   <= 1'b0;
      count    <= 2'd0;
      err_q    <= 1'b0;
      o_k      <= '0;
    end else begin
      state    <= state_nxt;
      err_q    <= (state == IDLE) && i_start && !legal;
      inflight <= issue;
      if (accept) begin
        sec     <= i_sec_level;
        o_k     <= '0;
        rd_ptr  <= '0;
        cap_ptr <= '0;
      end
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (state == DONE) rd_ptr <= '0;
      if (inflight) begin
        f_data[wr_idx] <= dec_word;
        f_last[wr_idx] <= (cap_ptr == AW'(N_WD - 1));
        wr_idx  <= ~wr_idx;
        cap_ptr <= cap_ptr + 1'b1;
        o_k     <= o_k | k_ins;
      end
      if (pop) rd_idx <= ~rd_idx;
      count <= count + 2'(inflight) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_kmat_decode_stream.sv
// tb/tb_kmat_decode_stream.sv - Directed bench for kmat_decode_stream at T=4, NBAR=8.
module tb_kmat_decode_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   sec_level = 3'd0;
  logic         k_mat_en;
  logic [3:0]   k_mat_addr;
  logic [63:0]  k_mat = '0;
  logic         kw_valid;
  logic [15:0]  kw_data;
  logic         kw_last;
  logic         kw_ready = 1'b1;
  logic [255:0] k;
  logic         done, busy, err;

  logic [63:0]  rom [16];
  logic [15:0]  ew [16];
  logic [255:0] exp_k;
  logic [16:0]  pops [$];
  int           base;
  int           n_assert = 0;
  int           n_fail = 0;
  int           d_idx, e_cnt, e_first, e_last;

  kmat_decode_stream dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sec_level(sec_level),
    .o_k_mat_en(k_mat_en), .o_k_mat_addr(k_mat_addr), .i_k_mat(k_mat),
    .o_kw_valid(kw_valid), .o_kw_data(kw_data), .o_kw_last(kw_last),
    .i_kw_ready(kw_ready), .o_k(k), .o_done(done), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (k_mat_en) k_mat <= rom[k_mat_addr];

  always @(negedge clk) if (kw_valid && kw_ready) pops.push_back({kw_last, kw_data});

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_k"}, k, '0);
    chk({tag, "_ctl"}, {kw_valid, kw_last, k_mat_en, done, busy, err}, '0);
    chk({tag, "_data"}, kw_data, '0);
    chk({tag, "_addr"}, k_mat_addr, '0);
  endtask

  task automatic check_stream(input string tag);
    int cnt;
    cnt = pops.size() - base;
    chk({tag, "_npops"}, cnt, 16);
    for (int w = 0; w < 16; w++)
      if (w < cnt) chk({tag, "_word"}, pops[base + w], {w == 15, ew[w]});
  endtask

  // mode 0: ready high; 1: stall then random ready; 2: stray start mid-run; 3: reset at cycle 5
  task automatic run(input logic [2:0] sec, input int mode,
                     output int done_idx, output int en_cnt, output int en_first, output int en_last);
    logic [15:0] held;
    done_idx = -1; en_cnt = 0; en_first = -1; en_last = -1; held = '0;
    base = pops.size();
    sec_level = sec; start = 1'b1; kw_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      kw_ready = 1'b1;
      if (mode == 1 && i >= 3 && i < 13) kw_ready = 1'b0;
      else if (mode == 1 && i >= 13) kw_ready = 1'($urandom_range(0, 1));
      start = (mode == 2 && i == 4);
      sec_level = (mode == 2 && i == 4) ? 3'd1 : sec;
      rst_n = !(mode == 3 && i == 5);
      #1;
      if (k_mat_en) begin
        en_cnt++;
        if (en_first < 0) en_first = i;
        en_last = i;
      end
      if (done && done_idx < 0) done_idx = i;
      if (mode == 0 && i == 0) chk("busy_after_start", busy, 1);
      if (mode == 1 && i == 4) held = kw_data;
      if (mode == 1 && i == 5) chk("stall_en_low", {kw_valid, k_mat_en}, 2'b10);
      if (mode == 1 && i == 12) chk("stall_hold", {kw_valid, kw_data}, {1'b1, held});
      if (mode == 3 && i == 6) chk_zero_outputs("mid_reset");
      if (mode != 3 && done_idx >= 0) break;
      if (mode == 3 && i == 30) break;
      @(posedge clk); #1;
    end
    start = 1'b0; rst_n = 1'b1; kw_ready = 1'b1; sec_level = sec;
    @(posedge clk); #1;
  endtask

  task automatic load_l5_const();
    for (int w = 0; w < 16; w++) begin
      rom[w] = {4{16'h1000}};
      ew[w]  = 16'h1111;
    end
    exp_k = {64{4'h1}};
  endtask

  initial begin
    load_l5_const();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(3'd5, 0, d_idx, e_cnt, e_first, e_last);
    chk("l5_done_cycle", d_idx, 18);
    chk("l5_en_count", e_cnt, 16);
    chk("l5_en_window", {16'(e_first), 16'(e_last)}, {16'd0, 16'd15});
    chk("l5_k", k, exp_k);
    chk("l5_idle_after", {busy, done}, 2'b00);
    check_stream("l5");

    for (int w = 0; w < 16; w++) begin
      rom[w] = {16'h8000, 16'h7FFF, 16'h1000, 16'h0FFF};
      ew[w]  = 16'h0004;
    end
    run(3'd1, 0, d_idx, e_cnt, e_first, e_last);
    chk("l1_done_cycle", d_idx, 18);
    chk("l1_k", k, {128'h0, {16{8'h04}}});
    check_stream("l1");

    exp_k = '0;
    for (int w = 0; w < 16; w++) begin
      rom[w] = {16'hF000, 16'h2000, 16'h2000, 16'hF000};
      ew[w]  = 16'h0048;
      exp_k[12*w +: 12] = 12'h048;
    end
    run(3'd3, 0, d_idx, e_cnt, e_first, e_last);
    chk("l3_k", k, exp_k);
    chk("l3_k_upper", k[255:192], '0);
    check_stream("l3");

    load_l5_const();
    run(3'd5, 1, d_idx, e_cnt, e_first, e_last);
    chk("bp_done_seen", d_idx >= 0, 1);
    chk("bp_en_count", e_cnt, 16);
    chk("bp_k", k, exp_k);
    check_stream("bp");

    for (int w = 0; w < 16; w++) begin
      rom[w] = {4{w[3:0], 12'h000}};
      ew[w]  = {4{w[3:0]}};
    end
    for (int i = 0; i < 64; i++) exp_k[4*i +: 4] = 4'(i / 4);
    run(3'd5, 1, d_idx, e_cnt, e_first, e_last);
    chk("order_k", k, exp_k);
    check_stream("order");

    sec_level = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_level_err", {err, busy, k_mat_en}, 3'b100);
    @(posedge clk); #1;
    chk("bad_level_err_clear", {err, busy, k_mat_en}, 3'b000);

    load_l5_const();
    run(3'd5, 2, d_idx, e_cnt, e_first, e_last);
    chk("stray_start_done", d_idx, 18);
    chk("stray_start_k", k, exp_k);

    run(3'd5, 3, d_idx, e_cnt, e_first, e_last);
    chk("reset_no_done", d_idx >= 0, 0);
    chk("reset_idle", busy, 0);

    run(3'd5, 0, d_idx, e_cnt, e_first, e_last);
    chk("post_reset_done", d_idx, 18);
    chk("post_reset_k", k, exp_k);
    check_stream("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/kmat_decode_stream.md
KMAT_DECODE_STREAM -- requirements
Module: kmat_decode_stream

Interface
REQ-001 SHALL have parameter T, default 4, number of 16-bit elements per memory word; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter NBAR, default 8, matrix dimension; the block holds N_EL = NBAR*NBAR elements and reads N_WD = N_EL/T words.
REQ-003 SHALL have parameter LEN_MU, default `L5_LEN_MU (256), the width of the full output string.
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have port i_start, input, 1 bit, a one-cycle start request.
REQ-007 SHALL have port i_sec_level, input, 3 bits: 1 = L1 (D=15, B=2), 3 = L3 (D=16, B=3), 5 = L5 (D=16, B=4).
REQ-008 SHALL have port o_k_mat_en, output, 1 bit, the read enable for the synchronous ROM/SRAM.
REQ-009 SHALL have port o_k_mat_addr, output, `CLOG2(N_WD) bits, the word address.
REQ-010 SHALL have port i_k_mat, input, T*16 bits; it returns the word addressed in the previous cycle, and element j sits in bits [16j+15:16j].
REQ-011 SHALL have port o_kw_valid, output, 1 bit, stream word valid.
REQ-012 SHALL have port o_kw_data, output, T*4 bits, the decoded word.
REQ-013 SHALL have port o_kw_last, output, 1 bit, marking the final stream word.
REQ-014 SHALL have port i_kw_ready, input, 1 bit, stream ready.
REQ-015 SHALL have port o_k, output, LEN_MU bits, the full decoded string.
REQ-016 SHALL have ports o_done, o_busy and o_err, outputs, 1 bit each, for completion pulse, run in progress and rejected start.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE; IDLE->RUN on i_start with a legal i_sec_level; RUN->DONE when the final stream word is popped; DONE->IDLE after one cycle.
REQ-018 SHALL, on an accepted start, latch i_sec_level, clear o_k to 0, reset the read and element pointers to 0, and assert o_busy from the next edge until the DONE->IDLE edge.
REQ-019 SHALL ignore i_start while in RUN or DONE.
REQ-020 SHALL, for i_start in IDLE with i_sec_level not in {1,3,5}, stay in IDLE, issue no read, and pulse o_err for exactly one cycle.
REQ-021 SHALL decode each element c (low D bits only; bit 15 is ignored at L1) as k = ((c + 2^(D-B-1)) >> (D-B)) mod 2^B, using D+1-bit internal arithmetic with wrap-around modulo 2^B.
REQ-022 SHALL buffer decoded words in a 2-entry output FIFO.
REQ-023 SHALL set o_k_mat_en = issue, where issue = RUN & rd_ptr<N_WD & (occupancy + inflight - pop) < 2, with pop = o_kw_valid & i_kw_ready.
REQ-024 SHALL drive o_k_mat_addr = rd_ptr, incrementing on every issue, and hold it at 0 whenever en is low in IDLE.
REQ-025 SHALL capture i_k_mat into the FIFO exactly one cycle after each issue; no word is dropped or duplicated under any ready pattern.
REQ-026 SHALL place decoded element j of a word at o_kw_data[jB+B-1:jB] and zero the bits above T*B.
REQ-027 SHALL place global element i (row-major, word w, lane j, i = wT+j) at o_k[iB+B-1:iB], written on FIFO capture; bits at or above N_EL*B remain 0.
REQ-028 SHALL present the FIFO head on o_kw_valid/o_kw_data, hold it stable while valid & !ready, and assert o_kw_last with word N_WD-1.
REQ-029 SHALL pulse o_done for one cycle on the edge following the final pop; o_k is stable from that edge until the next accepted start.
REQ-030 SHALL, with i_kw_ready held high, assert o_k_mat_en on the N_WD consecutive cycles following the start edge and raise o_done N_WD+2 cycles after the start edge (18 cycles for T=4).

Reset
REQ-031 SHALL, when i_rst_n=0 at an edge, enter IDLE, empty the FIFO, clear inflight, and zero every output: o_k, o_kw_data, o_kw_valid, o_kw_last, o_k_mat_en, o_k_mat_addr, o_done, o_busy and o_err.
REQ-032 SHALL, on reset mid-RUN, abandon the run with no o_done, and accept the next start normally.

Verification
REQ-033 SHALL cover L5, T=4, every element 0x1000, ready=1 -> o_k = 256'h1111...1 (64 nibbles), o_done 18 cycles after start, 16 stream words each 16'h1111.
REQ-034 SHALL cover L1 rounding with elements 0x0FFF, 0x1000, 0x7FFF, 0x8000 in lanes 0..3 -> decoded 0, 1, 0 (wrap), 0 (bit 15 ignored); o_k[255:128]=0.
REQ-035 SHALL cover L3 with 0xF000 -> 0 (wrap) and 0x2000 -> 1, 3-bit packing, and o_k[255:192]=0.
REQ-036 SHALL cover the REQ-033 data with i_kw_ready low for 10 cycles mid-run and then random -> en drops once the FIFO and inflight total 2, order is preserved, and o_k and the stream are identical to REQ-033.
REQ-037 SHALL cover: i_sec_level=2 -> one-cycle o_err and no en; i_start during RUN -> ignored; reset at cycle 5 of a run -> all outputs 0 next edge, no o_done, and a following L5 run passes REQ-033.
